// File: rtl/chan_err_pkg.sv
// Shared types and helpers for the chan_err_inj channel model: mode/burst
// enums, LFSR polynomial and saturating arithmetic.
package chan_err_pkg;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_RANDOM   = 2'b10,
        MODE_BURST    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_GAP   = 2'b10
    } burst_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

    // Right-shifting Galois form: feedback from bit 0 folds into the tap mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/chan_err_inj_if.sv
// Symbol stream between encoder, error injector and Viterbi decoder.
// master drives encoder symbols and observes the channel output; slave is the injector.
interface chan_err_inj_if #(
    parameter int SYM_W = 2
);
    logic             valid_i;
    logic [SYM_W-1:0] sym_i;
    logic             valid_o;
    logic [SYM_W-1:0] sym_o;
    logic             err_o;

    modport master (output valid_i, sym_i, input valid_o, sym_o, err_o);
    modport slave  (input valid_i, sym_i, output valid_o, sym_o, err_o);
endinterface

// File: rtl/chan_lfsr16.sv
// 16-bit Galois LFSR with seed load on reset/clear and a step enable.
// A zero seed would lock the register, so it is replaced by 1.
module chan_lfsr16
    import chan_err_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    output logic [15:0] state
);
    localparam logic [15:0] LOAD = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= LOAD;
        end else if (clear) begin
            state_reg <= LOAD;
        end else if (en) begin
            state_reg <= lfsr_next(state_reg);
        end
    end

    assign state = state_reg;
endmodule

// File: rtl/chan_err_inj.sv
// Bit-error channel model: registers each valid code symbol and XORs in an
// error mask (periodic / random / burst) inside a window. Optional trace: CHAN_ERR_TRACE_EN.
module chan_err_inj
    import chan_err_pkg::*;
#(
    parameter int          SYM_W       = 2,
    parameter int          PERIOD_LOG2 = 3,
    parameter int          WINDOW      = 256,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic [1:0]         mode_i,
    input  logic [SYM_W-1:0]   pattern_i,
    input  logic [7:0]         thresh_i,
    input  logic [7:0]         burst_len_i,
    input  logic [7:0]         gap_len_i,
    chan_err_inj_if.slave      bus,
    output logic [15:0]        err_sym_ct_o,
    output logic [15:0]        err_bit_ct_o
);
    localparam logic [16:0] WIN = 17'(WINDOW);

    mode_t            mode;
    logic             adv;
    logic             in_window;
    logic             inject;
    logic             burst_inj;
    logic [SYM_W-1:0] mask;
    logic [15:0]      lfsr_q;
    logic [15:0]      pop_acc [0:SYM_W];

    logic             valid_o_reg;
    logic [SYM_W-1:0] sym_o_reg;
    logic             err_o_reg;
    logic [15:0]      sym_ct_reg;
    logic [15:0]      err_sym_ct_reg;
    logic [15:0]      err_bit_ct_reg;

    burst_state_t     state_reg, state_next;
    logic [7:0]       run_reg, run_next;
    logic [7:0]       burst_len_eff, gap_len_eff;

    assign mode      = mode_t'(mode_i);
    assign adv       = bus.valid_i && !clear_i;
    assign in_window = (WINDOW == 0) || ({1'b0, sym_ct_reg} < WIN);

    chan_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_i),
        .en    (adv && (mode == MODE_RANDOM)),
        .state (lfsr_q)
    );

    // Bit-error weight of the mask, accumulated one pattern bit per stage.
    assign pop_acc[0] = 16'd0;
    generate
        for (genvar gi = 0; gi < SYM_W; gi++) begin : g_pop
            assign pop_acc[gi+1] = pop_acc[gi] + 16'(pattern_i[gi]);
        end
    endgenerate

    always_comb begin
        inject = 1'b0;
        if (in_window) begin
            case (mode)
                MODE_PERIODIC: inject = (sym_ct_reg[PERIOD_LOG2-1:0] == '0);
                MODE_RANDOM:   inject = (lfsr_q[7:0] < thresh_i);
                MODE_BURST:    inject = burst_inj;
                default:       inject = 1'b0;
            endcase
        end
    end

    assign mask = inject ? pattern_i : '0;

    // Burst FSM: run_reg holds the symbols left in the current run, this one included.
    assign burst_len_eff = (burst_len_i == 8'd0) ? 8'd1 : burst_len_i;
    assign gap_len_eff   = (gap_len_i == 8'd0) ? 8'd1 : gap_len_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            run_reg   <= 8'd0;
        end else if (clear_i) begin
            state_reg <= ST_IDLE;
            run_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            run_reg   <= run_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        run_next   = run_reg;
        if (mode != MODE_BURST || !in_window) begin
            state_next = ST_IDLE;
            run_next   = 8'd0;
        end else if (bus.valid_i) begin
            case (state_reg)
                ST_IDLE: begin
                    if (burst_len_eff == 8'd1) begin
                        state_next = ST_GAP;
                        run_next   = gap_len_eff;
                    end else begin
                        state_next = ST_BURST;
                        run_next   = burst_len_eff - 8'd1;
                    end
                end
                ST_BURST: begin
                    if (run_reg <= 8'd1) begin
                        state_next = ST_GAP;
                        run_next   = gap_len_eff;
                    end else begin
                        run_next = run_reg - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (run_reg <= 8'd1) begin
                        state_next = ST_BURST;
                        run_next   = burst_len_eff;
                    end else begin
                        run_next = run_reg - 8'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    run_next   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        burst_inj = (state_reg == ST_IDLE) || (state_reg == ST_BURST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o_reg    <= 1'b0;
            sym_o_reg      <= '0;
            err_o_reg      <= 1'b0;
            sym_ct_reg     <= 16'd0;
            err_sym_ct_reg <= 16'd0;
            err_bit_ct_reg <= 16'd0;
        end else begin
            valid_o_reg <= bus.valid_i;
            err_o_reg   <= 1'b0;
            if (clear_i) begin
                sym_ct_reg     <= 16'd0;
                err_sym_ct_reg <= 16'd0;
                err_bit_ct_reg <= 16'd0;
                if (bus.valid_i) begin
                    sym_o_reg <= bus.sym_i;
                end
            end else if (bus.valid_i) begin
                sym_o_reg  <= bus.sym_i ^ mask;
                err_o_reg  <= inject;
                sym_ct_reg <= sat_inc(sym_ct_reg);
                if (inject) begin
                    err_sym_ct_reg <= sat_inc(err_sym_ct_reg);
                    err_bit_ct_reg <= sat_add(err_bit_ct_reg, pop_acc[SYM_W]);
                end
            end
        end
    end

`ifdef CHAN_ERR_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst && adv && inject) begin
            $display("chan_err_inj: sym_ct=%0d mode=%0d sym_i=%b sym_o=%b err_sym_ct=%0d err_bit_ct=%0d",
                     sym_ct_reg, mode_i, bus.sym_i, bus.sym_i ^ mask,
                     sat_inc(err_sym_ct_reg), sat_add(err_bit_ct_reg, pop_acc[SYM_W]));
        end
        if (rst && adv && (mask != '0) && !in_window) begin
            $error("chan_err_inj: bit flip outside error window at sym_ct=%0d", sym_ct_reg);
        end
    end
`endif

    assign bus.valid_o   = valid_o_reg;
    assign bus.sym_o     = sym_o_reg;
    assign bus.err_o     = err_o_reg;
    assign err_sym_ct_o  = err_sym_ct_reg;
    assign err_bit_ct_o  = err_bit_ct_reg;
endmodule

// File: tb/tb_chan_err_inj.sv
// Scoreboard bench for chan_err_inj: stimulus queues the expected channel output,
// a monitor branch pops and compares on every valid_o.
module tb_chan_err_inj;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear_i;
    logic [1:0]  mode_i;
    logic [1:0]  pattern_i;
    logic [7:0]  thresh_i;
    logic [7:0]  burst_len_i;
    logic [7:0]  gap_len_i;
    logic [15:0] err_sym_ct_o;
    logic [15:0] err_bit_ct_o;

    chan_err_inj_if #(.SYM_W(2)) ifc ();

    chan_err_inj #(
        .SYM_W       (2),
        .PERIOD_LOG2 (3),
        .WINDOW      (256),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear_i),
        .mode_i       (mode_i),
        .pattern_i    (pattern_i),
        .thresh_i     (thresh_i),
        .burst_len_i  (burst_len_i),
        .gap_len_i    (gap_len_i),
        .bus          (ifc),
        .err_sym_ct_o (err_sym_ct_o),
        .err_bit_ct_o (err_bit_ct_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [2:0]  exp_q [$];
    logic [2:0]  mon_e;
    logic        inj;
    logic [1:0]  s;
    logic [1:0]  es;
    logic [15:0] model;
    int          n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One valid symbol; expected {sym_o, err_o} goes onto the scoreboard.
    task automatic send(input logic [1:0] sym, input logic [1:0] exp_sym, input logic exp_err,
                        input logic clr = 1'b0);
        ifc.valid_i = 1'b1;
        ifc.sym_i   = sym;
        clear_i     = clr;
        exp_q.push_back({exp_sym, exp_err});
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    task automatic idle(input int cycles);
        ifc.valid_i = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        ifc.valid_i = 1'b0;
        clear_i     = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        clear_i     = 1'b0;
        mode_i      = 2'b00;
        pattern_i   = 2'b00;
        thresh_i    = 8'd0;
        burst_len_i = 8'd0;
        gap_len_i   = 8'd0;
        ifc.valid_i = 1'b0;
        ifc.sym_i   = 2'b00;
        fork
            begin : stimulus
                #1 rst = 1'b0;
                #2;
                chk("reset valid_o", ifc.valid_o, 0);
                chk("reset sym_o", ifc.sym_o, 0);
                chk("reset err_o", ifc.err_o, 0);
                chk("reset err_sym_ct", err_sym_ct_o, 0);
                chk("reset err_bit_ct", err_bit_ct_o, 0);
                @(posedge clk);
                #1 rst = 1'b1;
                idle(2);

                // pass-through: mask never applied
                mode_i    = 2'b00;
                pattern_i = 2'b11;
                for (int i = 0; i < 4; i++) send(2'(i), 2'(i), 1'b0);
                idle(2);
                chk("pass err_sym_ct", err_sym_ct_o, 0);

                // periodic: symbols 0, 8, 16 corrupted
                do_clear();
                mode_i    = 2'b01;
                pattern_i = 2'b01;
                for (int i = 0; i < 20; i++) begin
                    inj = (i % 8 == 0);
                    send(2'b00, inj ? 2'b01 : 2'b00, inj);
                end
                idle(2);
                chk("periodic err_sym_ct", err_sym_ct_o, 3);
                chk("periodic err_bit_ct", err_bit_ct_o, 3);

                // clear together with valid on an injection slot
                do_clear();
                for (int i = 0; i < 8; i++) begin
                    inj = (i == 0);
                    send(2'b10, inj ? 2'b11 : 2'b10, inj);
                end
                send(2'b10, 2'b10, 1'b0, 1'b1);
                idle(1);
                chk("clear err_sym_ct", err_sym_ct_o, 0);
                chk("clear err_bit_ct", err_bit_ct_o, 0);
                send(2'b00, 2'b01, 1'b1);
                idle(2);
                chk("post-clear err_sym_ct", err_sym_ct_o, 1);

                // valid gaps: same positions as a gapless run, output held
                do_clear();
                pattern_i = 2'b10;
                for (int i = 0; i < 10; i++) begin
                    s   = 2'(i);
                    inj = (i % 8 == 0);
                    es  = inj ? (s ^ 2'b10) : s;
                    send(s, es, inj);
                    idle(3);
                    chk("gap valid_o", ifc.valid_o, 0);
                    chk("gap sym_o held", ifc.sym_o, es);
                end
                chk("gap err_sym_ct", err_sym_ct_o, 2);
                chk("gap err_bit_ct", err_bit_ct_o, 2);

                // window: 32 injections below symbol 256, nothing after
                do_clear();
                pattern_i = 2'b11;
                for (int i = 0; i < 300; i++) begin
                    inj = (i < 256) && (i % 8 == 0);
                    send(2'b00, inj ? 2'b11 : 2'b00, inj);
                end
                idle(2);
                chk("window err_sym_ct", err_sym_ct_o, 32);
                chk("window err_bit_ct", err_bit_ct_o, 64);
                for (int i = 0; i < 20; i++) send(2'b01, 2'b01, 1'b0);
                idle(2);
                chk("window hold err_sym_ct", err_sym_ct_o, 32);

                // burst len 3 gap 5: symbols 0-2 and 8-10
                do_clear();
                mode_i      = 2'b11;
                burst_len_i = 8'd3;
                gap_len_i   = 8'd5;
                pattern_i   = 2'b11;
                for (int i = 0; i < 16; i++) begin
                    s   = 2'(i);
                    inj = (i < 3) || (i >= 8 && i < 11);
                    send(s, inj ? (s ^ 2'b11) : s, inj);
                end
                idle(2);
                chk("burst err_sym_ct", err_sym_ct_o, 6);
                chk("burst err_bit_ct", err_bit_ct_o, 12);

                // reset mid-burst, then a fresh burst on the first symbol
                do_clear();
                send(2'b01, 2'b10, 1'b1);
                send(2'b10, 2'b01, 1'b1);
                ifc.valid_i = 1'b0;
                @(negedge clk);
                #1 rst = 1'b0;
                #1;
                chk("rst valid_o", ifc.valid_o, 0);
                chk("rst sym_o", ifc.sym_o, 0);
                chk("rst err_o", ifc.err_o, 0);
                chk("rst err_sym_ct", err_sym_ct_o, 0);
                chk("rst err_bit_ct", err_bit_ct_o, 0);
                @(posedge clk);
                #1 rst = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    inj = (i < 3);
                    send(2'b00, inj ? 2'b11 : 2'b00, inj);
                end
                idle(2);
                chk("rst burst err_sym_ct", err_sym_ct_o, 3);
                chk("rst burst err_bit_ct", err_bit_ct_o, 6);

                // random, threshold 0: never injects
                do_clear();
                mode_i   = 2'b10;
                thresh_i = 8'd0;
                for (int i = 0; i < 1000; i++) send(2'(i), 2'(i), 1'b0);
                idle(2);
                chk("rand0 err_sym_ct", err_sym_ct_o, 0);

                // random, threshold 128 against a reference LFSR
                do_clear();
                thresh_i  = 8'd128;
                pattern_i = 2'b01;
                model     = 16'hACE1;
                n         = 0;
                for (int i = 0; i < 64; i++) begin
                    s   = 2'(i);
                    inj = (model[7:0] < 8'd128);
                    send(s, inj ? (s ^ 2'b01) : s, inj);
                    if (inj) n++;
                    model = model[0] ? ((model >> 1) ^ 16'hB400) : (model >> 1);
                end
                idle(2);
                chk("rand128 err_sym_ct", err_sym_ct_o, 32'(n));
                chk("rand128 err_bit_ct", err_bit_ct_o, 32'(n));

                idle(3);
                chk("scoreboard drained", exp_q.size(), 0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst === 1'b1 && ifc.valid_o === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected output: sym_o %b err_o %b with empty scoreboard",
                                     ifc.sym_o, ifc.err_o);
                        end else begin
                            mon_e = exp_q.pop_front();
                            if ({ifc.sym_o, ifc.err_o} !== mon_e) begin
                                errors++;
                                $display("FAIL symbol: got sym_o %b err_o %b expected sym_o %b err_o %b",
                                         ifc.sym_o, ifc.err_o, mon_e[2:1], mon_e[0]);
                            end
                        end
                    end
                end
            end
            begin : watchdog
                repeat (20000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL timeout: ran 20000 cycles, expected to finish sooner");
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chan_err_inj.md
Name: chan_err_inj

Overview:
- Configurable bit-error channel model between the rate-1/2 convolutional encoder output and the Viterbi decoder input.
- Registers each valid 2-bit code symbol and XORs a programmable error mask into it, following a periodic, pseudo-random or burst error pattern, inside an error window.
- Keeps saturating symbol-error and bit-error counts so decoder BER tests can be scored against the injected error load.

Parameters:
- SYM_W, 2, code symbol width (encoder output bits per step).
- PERIOD_LOG2, 3, periodic mode injects once every 2**PERIOD_LOG2 valid symbols.
- WINDOW, 256, injection only while symbol count < WINDOW; 0 = unlimited.
- LFSR_SEED, 16'hACE1, LFSR load value at reset/clear; 0 is illegal and is replaced by 16'h0001.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous restart: counters, window, burst FSM, LFSR.
- mode_i  in  2  00 pass-through, 01 periodic, 10 random, 11 burst.
- pattern_i  in  SYM_W  error mask XORed into a symbol on an injection.
- thresh_i  in  8  random mode: inject when lfsr[7:0] < thresh_i.
- burst_len_i  in  8  burst mode: corrupted symbols per burst (0 treated as 1).
- gap_len_i  in  8  burst mode: clean symbols between bursts (0 treated as 1).
- valid_i  in  1  sym_i is valid this cycle.
- sym_i  in  SYM_W  encoder symbol.
- valid_o  out  1  registered valid_i.
- sym_o  out  SYM_W  possibly corrupted symbol; drives the decoder d_in.
- err_o  out  1  high with valid_o when sym_o carries an injected error.
- err_sym_ct_o  out  16  saturating count of corrupted symbols.
- err_bit_ct_o  out  16  saturating count of flipped bits.

Behaviour:
- Reset (rst low, async): valid_o=0, sym_o=0, err_o=0, both counters 0, sym_ct=0, burst FSM IDLE, LFSR=LFSR_SEED.
- Latency: exactly 1 cycle. valid_o <= valid_i every cycle. When valid_i=1: sym_o <= sym_i ^ mask, err_o <= inject. When valid_i=0: sym_o holds, err_o <= 0.
- Advancement: sym_ct (16-bit, saturates at 16'hFFFF), LFSR and burst counters advance only on valid_i cycles.
- Window: in_window = (WINDOW==0) || (sym_ct < WINDOW). When in_window is false, inject=0.
- Periodic: inject = in_window && sym_ct[PERIOD_LOG2-1:0]==0, so symbols 0, 2**P, 2*2**P, ... are corrupted.
- Random: 16-bit Galois LFSR, taps 16'hB400. It shifts on every valid_i while mode_i==10. inject = in_window && lfsr[7:0] < thresh_i, using the pre-shift value. thresh_i=0 never injects.
- Burst FSM, states IDLE / BURST / GAP:
  - IDLE -> BURST on a valid in_window symbol in mode 11; that symbol is the first corrupted one.
  - BURST corrupts burst_len_i symbols, then moves to GAP.
  - GAP passes gap_len_i symbols clean, then moves to BURST.
  - Any mode other than 11, or in_window false, forces IDLE on the next clock.
  - Run lengths are latched on entry to each state.
- Mask: pattern_i when inject, else 0. inject with pattern_i==0 still counts as a symbol error but adds 0 bits.
- Counters: when inject, err_sym_ct += 1 and err_bit_ct += popcount(pattern_i). Both saturate at 16'hFFFF with no wrap.
- Mode 00: inject=0 always.
- clear_i has priority over valid_i in the same cycle: that symbol passes uncorrupted (err_o=0), counters/sym_ct go to 0, FSM goes to IDLE, LFSR reloads. valid_o still follows valid_i.
- mode_i, pattern_i, thresh_i, burst_len_i and gap_len_i are sampled each valid cycle; changing them mid-stream is legal.

Optional Feature:
- CHAN_ERR_TRACE_EN defined: each injection prints one simulation line: sym_ct, mode, sym_i, sym_o, running counts. A check flags an error if a flip occurs while in_window is false.
- Undefined: no trace or check code is compiled; RTL is identical otherwise.

Decomposition:
- Package chan_err_pkg: mode enum (MODE_PASS, MODE_PERIODIC, MODE_RANDOM, MODE_BURST), burst state enum, LFSR_TAPS constant, saturating-increment function.
- Sub-module chan_lfsr16: seed load, enable, clear, 16-bit state output.

Test Plan:
- Periodic mode: P=3, pattern 01, 20 valid symbols of 00 -> sym_o=01 at symbols 0, 8, 16; err_sym_ct=3, err_bit_ct=3.
- Window: periodic mode, WINDOW=256, 300 symbols -> 32 injections, none at or after symbol 256; counters then hold.
- Burst mode: len 3, gap 5, pattern 11, 16 symbols -> symbols 0-2 and 8-10 corrupted; err_sym_ct=6, err_bit_ct=12.
- Random mode:
  - thresh 0 over 1000 symbols -> 0 errors.
  - thresh 128 -> err_o sequence matches a bench LFSR model bit-exactly.
- Reset and clear:
  - rst low mid-burst -> all outputs 0 immediately; after release, first valid symbol starts a new burst.
  - clear_i together with valid_i -> that symbol clean, counters 0.
- Valid gaps: valid_i low 3 cycles between symbols in periodic mode -> valid_o low, sym_o held, injection positions unchanged vs gapless run.
